uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter. It is the send-side counterpart of the team's 8-bit serial receiver. The block accepts one byte per valid/ready handshake and serialises it as a standard frame: one start bit (0), eight data bits LSB-first, one stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It sits between the system's byte source and the tx pin; the line idles high.

Parameters:
CLKS_PER_BIT, 10, clocks per serial bit period; legal range 2..65535
DATA_BITS, 8, data bits per frame; fixed at 8 for this release

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  8  byte to send; sampled only on handshake
tx_valid  input  1  source has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
tx_serial  output  1  serial line; idles 1
tx_busy  output  1  a frame is in progress (START/DATA/STOP)
tx_done  output  1  one-cycle pulse on the final clock of the stop bit

Behaviour:
- Reset (rst=1 at a clk edge), effective the next cycle:
  - state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, tx_ready=1.
  - Bit-period counter and bit index cleared; shift contents discarded.
- Reset mid-frame: the frame is abandoned. tx_serial returns to 1 the cycle after rst is sampled; no tx_done is produced.
- Handshake: a transfer occurs on any edge where tx_valid=1 and tx_ready=1. tx_data is latched into the shift register on that edge.
- tx_ready is combinational from state:
  - 1 in IDLE.
  - 1 on the last clock of STOP (counter==CLKS_PER_BIT-1).
  - 0 otherwise.
- tx_valid while tx_ready=0 is ignored; no data is latched.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_serial=1. On transfer -> START, counter=0.
  - START: tx_serial=0 for CLKS_PER_BIT clocks. At counter==CLKS_PER_BIT-1 -> DATA, bit index=0, counter=0.
  - DATA: tx_serial = shift register bit 0. At counter==CLKS_PER_BIT-1 the register shifts right by one and the index increments. After index 7 completes -> STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT clocks. On the last clock tx_done=1. Then:
    - if a transfer occurs on that clock -> START (back-to-back, no idle gap);
    - else -> IDLE.
- Latency: the start bit appears on tx_serial the cycle after the accept edge.
- Frame length: 10*CLKS_PER_BIT clocks from the first start-bit cycle to the end of the stop bit.
- Counter: width $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1 and never exceeds that value.
- Bit index: 3 bits, counts 0..7.
- tx_busy=1 in START, DATA and STOP. It stays 1 across a back-to-back boundary.
- tx_serial is driven from a flop, so it is glitch-free.

Decomposition:
- Shared package uart_pkg:
  - state enum uart_tx_state_t {IDLE, START, DATA, STOP};
  - localparams START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, FRAME_BITS=10.
- One sub-module, flex_pts_sr:
  - parameterised-width parallel-to-serial shift register, LSB-first;
  - ports: clk, rst, load_enable, shift_enable, parallel_in, serial_out.
  - The FSM, bit-period counter and bit index stay in uart_tx.

Test Plan:
- Reset check: rst=1 for 3 cycles, then release -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
- Single frame, CLKS_PER_BIT=10, tx_data=8'hA5 pulsed valid for one cycle:
  - tx_serial = 0 for 10 clocks, then 1,0,1,0,0,1,0,1 for 10 clocks each, then 1 for 10 clocks;
  - tx_done pulses on clock 100 after the accept;
  - tx_ready=0 from clock 1 to clock 99.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF:
  - second accept on the last stop clock of frame 1;
  - 200 contiguous frame clocks with no idle cycle;
  - tx_busy never drops between frames.
- Busy rejection: tx_valid=1 with 8'h3C for 5 cycles during the DATA state of an 8'h55 frame, then dropped -> only 8'h55 is transmitted; no second frame starts.
- Reset mid-frame: assert rst at clock 35 of an 8'hF0 frame -> tx_serial=1 and tx_ready=1 on the next cycle; no tx_done; a new 8'h0F frame then transmits correctly.
- Minimum period, CLKS_PER_BIT=2, tx_data=8'h81 -> 20-clock frame: 0,0 | 1,1 | 0×12 | 1,1 | 1,1; tx_done on clock 20.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-source to transmitter handshake plus serial line and status.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_serial,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, LSB first; load has priority over shift.
module flex_pts_sr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_enable,
  input  logic             shift_enable,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_enable) begin
      sr_d = parallel_in;
    end else if (shift_enable) begin
      sr_d = sr_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial_out = sr_q[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit,
// each bit held CLKS_PER_BIT clocks. tx_serial comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave tx
);

  localparam int unsigned  CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LastBit = 3'(DATA_BITS - 1);

  uart_tx_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            tx_serial_q, tx_serial_d;
  logic            cnt_last, ready, accept, shift_en, sr_bit;

  assign cnt_last = (cnt_q == CntMax);
  assign ready    = (state_q == IDLE) || ((state_q == STOP) && cnt_last);
  assign accept   = tx.tx_valid && ready;

  // The shifter runs one bit ahead of the line: it shifts on the same edge
  // that copies its current LSB into tx_serial_q.
  flex_pts_sr #(
    .WIDTH(DATA_BITS)
  ) u_sr (
    .clk         (clk),
    .rst         (rst),
    .load_enable (accept),
    .shift_enable(shift_en),
    .parallel_in (tx.tx_data),
    .serial_out  (sr_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    bit_idx_d   = bit_idx_q;
    tx_serial_d = tx_serial_q;
    shift_en    = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
    end
    case (state_q)
      IDLE: begin
        tx_serial_d = IDLE_LEVEL;
        if (accept) begin
          state_d     = START;
          tx_serial_d = START_BIT;
        end
      end
      START: begin
        if (cnt_last) begin
          state_d     = DATA;
          bit_idx_d   = '0;
          shift_en    = 1'b1;
          tx_serial_d = sr_bit;
        end
      end
      DATA: begin
        if (cnt_last) begin
          shift_en  = 1'b1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastBit) begin
            state_d     = STOP;
            tx_serial_d = STOP_BIT;
          end else begin
            tx_serial_d = sr_bit;
          end
        end
      end
      STOP: begin
        if (cnt_last) begin
          if (accept) begin
            state_d     = START;
            tx_serial_d = START_BIT;
          end else begin
            state_d     = IDLE;
            tx_serial_d = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        tx_serial_d = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      tx_serial_q <= IDLE_LEVEL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_serial_q <= tx_serial_d;
    end
  end

  assign tx.tx_ready  = ready;
  assign tx.tx_serial = tx_serial_q;
  assign tx.tx_busy   = (state_q != IDLE);
  assign tx.tx_done   = (state_q == STOP) && cnt_last;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (10 and 2 clocks per bit) checked every
// cycle against a frame-position model of the line.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned NA = 10;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       drv_rst;
  logic       drv_valid;
  logic [7:0] drv_data;
  int         sel;
  int         n;

  uart_tx_if if_a ();
  uart_tx_if if_b ();

  assign if_a.tx_data  = drv_data;
  assign if_b.tx_data  = drv_data;
  assign if_a.tx_valid = (sel == 0) && drv_valid;
  assign if_b.tx_valid = (sel == 1) && drv_valid;

  uart_tx #(
    .CLKS_PER_BIT(NA),
    .DATA_BITS   (8)
  ) dut_a (
    .clk(clk),
    .rst(drv_rst),
    .tx (if_a)
  );

  uart_tx #(
    .CLKS_PER_BIT(NB),
    .DATA_BITS   (8)
  ) dut_b (
    .clk(clk),
    .rst(drv_rst),
    .tx (if_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pos = 0 when idle, else 1..FRAME_BITS*n = clock within the frame.
  int         pos;
  logic [7:0] cur;
  int         n_done;
  int         cyc;
  logic [7:0] acc_q[$];
  int         acc_cyc[$];

  function automatic logic line_level(logic [7:0] b, int bit_pos);
    logic [9:0] frame;
    frame = {STOP_BIT, b, START_BIT};
    return frame[bit_pos];
  endfunction

  function automatic logic [3:0] observed();
    if (sel == 0) return {if_a.tx_serial, if_a.tx_ready, if_a.tx_busy, if_a.tx_done};
    return {if_b.tx_serial, if_b.tx_ready, if_b.tx_busy, if_b.tx_done};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare {serial, ready, busy, done} for this cycle, advance model, clock.
  task automatic step(string tag);
    logic [3:0] exp;
    int         last;
    last = FRAME_BITS * n;
    if (pos == 0) exp = 4'b1100;
    else exp = {line_level(cur, (pos - 1) / n), pos == last, 1'b1, pos == last};
    check($sformatf("%s cyc%0d pos%0d ser/rdy/busy/done", tag, cyc, pos), 32'(observed()),
          32'(exp));
    if (pos == last) n_done++;
    if (drv_rst) begin
      pos = 0;
    end else if (drv_valid && (pos == 0 || pos == last)) begin
      cur = drv_data;
      pos = 1;
      acc_q.push_back(drv_data);
      acc_cyc.push_back(cyc);
    end else if (pos == last) begin
      pos = 0;
    end else if (pos > 0) begin
      pos++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(string tag, int cycles);
    repeat (cycles) step(tag);
  endtask

  task automatic clear();
    n_done = 0;
    acc_q.delete();
    acc_cyc.delete();
  endtask

  task automatic send(string tag, logic [7:0] b, int idle_after);
    drv_valid = 1'b1;
    drv_data  = b;
    step(tag);
    drv_valid = 1'b0;
    run(tag, FRAME_BITS * n + idle_after);
  endtask

  task automatic rand_stream(string tag, int cycles);
    clear();
    for (int i = 0; i < cycles; i++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_data  = 8'($urandom);
      step(tag);
    end
    drv_valid = 1'b0;
    run(tag, FRAME_BITS * n + 2);
    check({tag, " frames completed"}, n_done, acc_q.size());
  endtask

  initial begin
    sel       = 0;
    n         = NA;
    pos       = 0;
    cyc       = 0;
    drv_rst   = 1'b1;
    drv_valid = 1'b0;
    drv_data  = '0;
    clear();
    repeat (3) @(posedge clk);
    #1;
    drv_rst = 1'b0;

    step("reset_a");
    sel = 1;
    n   = NB;
    step("reset_b");
    sel = 0;
    n   = NA;

    clear();
    send("single_a5", 8'hA5, 3);
    check("single_a5 done count", n_done, 1);
    check("single_a5 accepts", acc_q.size(), 1);

    // Valid held high: second byte must be taken on the last stop clock.
    clear();
    drv_valid = 1'b1;
    drv_data  = 8'h00;
    for (int i = 0; i < 2 * FRAME_BITS * n + 5; i++) begin
      step("b2b");
      if (acc_q.size() == 1) drv_data = 8'hFF;
      if (acc_q.size() == 2) drv_valid = 1'b0;
    end
    check("b2b done count", n_done, 2);
    check("b2b accepts", acc_q.size(), 2);
    if (acc_cyc.size() == 2) check("b2b accept spacing", acc_cyc[1] - acc_cyc[0], FRAME_BITS * n);

    clear();
    drv_valid = 1'b1;
    drv_data  = 8'h55;
    step("busy_rej");
    drv_valid = 1'b0;
    run("busy_rej", 24);
    drv_valid = 1'b1;
    drv_data  = 8'h3C;
    run("busy_rej", 5);
    drv_valid = 1'b0;
    run("busy_rej", FRAME_BITS * n - 30 + 1 + 20);
    check("busy_rej accepts", acc_q.size(), 1);
    check("busy_rej done count", n_done, 1);

    clear();
    drv_valid = 1'b1;
    drv_data  = 8'hF0;
    step("rst_mid");
    drv_valid = 1'b0;
    run("rst_mid", 34);
    check("rst_mid frame position", pos, 35);
    drv_rst = 1'b1;
    step("rst_mid");
    drv_rst = 1'b0;
    run("rst_mid idle", 15);
    check("rst_mid no done", n_done, 0);
    clear();
    send("after_rst_0f", 8'h0F, 3);
    check("after_rst done count", n_done, 1);

    rand_stream("rand_a", 400);

    sel = 1;
    n   = NB;
    clear();
    send("min_81", 8'h81, 3);
    check("min_81 done count", n_done, 1);
    rand_stream("rand_b", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
